// File: rtl/video_sprite_ctrl.sv
// rtl/video_sprite_ctrl.sv - sprite shadow/commit registers, animation pager and blanking-drained pixel FIFO
`ifndef H_SIZE
`define H_SIZE 11
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif

module video_sprite_ctrl #(
    parameter int RGB_SIZE      = 12,
    parameter int SPRITE_RAM_AW = 10,
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int FIFO_DEPTH    = 8,
    parameter int ANIM_FRAMES   = 4,
    localparam int PAGE_W       = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [31:0]              cfg_wdata,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [SPRITE_RAM_AW-1:0] pix_addr,
    input  logic [RGB_SIZE-1:0]      pix_data,
    input  logic [`H_SIZE-1:0]       xx,
    input  logic [`V_SIZE-1:0]       yy,
    output logic [31:0]              x0,
    output logic [31:0]              y0,
    output logic                     sprite_en,
    output logic [PAGE_W-1:0]        anim_page,
    output logic                     sprite_ram_we,
    output logic [SPRITE_RAM_AW-1:0] sprite_ram_addr_w,
    output logic [RGB_SIZE-1:0]      sprite_ram_din,
    output logic                     frame_tick
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SPRITE_RAM_AW + RGB_SIZE;
    localparam logic [`H_SIZE-1:0] H_LIM = `H_SIZE'(H_DISPLAY);
    localparam logic [`V_SIZE-1:0] V_LIM = `V_SIZE'(V_DISPLAY);
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } drain_state_t;

    logic [31:0] sh_x;
    logic [31:0] sh_y;
    logic        sh_en;
    logic [7:0]  sh_period;
    logic        sh_anim_rst;

    logic        vblank_r;
    logic        vblank_d;
    logic        commit_evt;
    logic        blank;
    logic [7:0]  anim_cnt;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    drain_state_t     state;

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg_wdata[31:17], cfg_wdata[7:1]};

    assign blank      = (xx >= H_LIM) || (yy >= V_LIM);
    assign commit_evt = vblank_r && !vblank_d;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign pix_ready  = !fifo_full;
    assign push       = pix_valid && pix_ready;
    assign pop        = (state == S_DRAIN) && blank && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_r <= 1'b0;
            vblank_d <= 1'b0;
        end else begin
            vblank_r <= (yy >= V_LIM);
            vblank_d <= vblank_r;
        end
    end

    // A write landing in the commit cycle is assigned after the commit logic, so it
    // overrides the anim_reset self-clear and waits in the shadow for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x        <= '0;
            sh_y        <= '0;
            sh_en       <= 1'b0;
            sh_period   <= '0;
            sh_anim_rst <= 1'b0;
            x0          <= '0;
            y0          <= '0;
            sprite_en   <= 1'b0;
            frame_tick  <= 1'b0;
            anim_cnt    <= '0;
            anim_page   <= '0;
        end else begin
            frame_tick <= commit_evt;
            if (commit_evt) begin
                x0          <= sh_x;
                y0          <= sh_y;
                sprite_en   <= sh_en;
                sh_anim_rst <= 1'b0;
                if (sh_anim_rst) begin
                    anim_cnt  <= '0;
                    anim_page <= '0;
                end else if (sh_period != 8'd0) begin
                    if (anim_cnt >= sh_period - 8'd1) begin
                        anim_cnt  <= '0;
                        anim_page <= (ANIM_FRAMES > 1) ? anim_page + 1'b1 : '0;
                    end else begin
                        anim_cnt <= anim_cnt + 8'd1;
                    end
                end
            end
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: sh_x <= cfg_wdata;
                    2'd1: sh_y <= cfg_wdata;
                    2'd2: begin
                        sh_en       <= cfg_wdata[0];
                        sh_period   <= cfg_wdata[15:8];
                        sh_anim_rst <= cfg_wdata[16];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr, pix_data};
        end
    end

    // Pop happens only while blanking; the RAM write follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            sprite_ram_we     <= 1'b0;
            sprite_ram_addr_w <= '0;
            sprite_ram_din    <= '0;
        end else begin
            sprite_ram_we <= pop;
            if (pop) begin
                {sprite_ram_addr_w, sprite_ram_din} <= fifo_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case (state)
                S_IDLE: begin
                    if (blank && !fifo_empty) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!blank || fifo_empty) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_sprite_ctrl.sv
// tb/tb_video_sprite_ctrl.sv - randomized self-checking bench for video_sprite_ctrl
module tb_video_sprite_ctrl;
    localparam int DEPTH  = 8;
    localparam int FRAMES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_addr = '0;
    logic [11:0] pix_data = '0;
    logic [10:0] xx = '0;
    logic [9:0]  yy = '0;
    logic [31:0] x0;
    logic [31:0] y0;
    logic        sprite_en;
    logic [1:0]  anim_page;
    logic        sprite_ram_we;
    logic [9:0]  sprite_ram_addr_w;
    logic [11:0] sprite_ram_din;
    logic        frame_tick;

    video_sprite_ctrl #(
        .RGB_SIZE(12), .SPRITE_RAM_AW(10), .H_DISPLAY(640), .V_DISPLAY(480),
        .FIFO_DEPTH(DEPTH), .ANIM_FRAMES(FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_data(pix_data),
        .xx(xx), .yy(yy), .x0(x0), .y0(y0), .sprite_en(sprite_en), .anim_page(anim_page),
        .sprite_ram_we(sprite_ram_we), .sprite_ram_addr_w(sprite_ram_addr_w),
        .sprite_ram_din(sprite_ram_din), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_sh_x = '0, m_sh_y = '0, m_sh_ctrl = '0;
    logic [31:0] m_x0 = '0, m_y0 = '0;
    logic        m_en = 1'b0, m_tick = 1'b0;
    int          m_cnt = 0, m_page = 0;
    logic        vb_q = 1'b0, vb_qq = 1'b0;
    logic [21:0] q[$];
    int          pop_xx[$];
    int          n_ticks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        logic        t_rst   = rst;
        logic        t_we    = cfg_we;
        logic [1:0]  t_addr  = cfg_addr;
        logic [31:0] t_data  = cfg_wdata;
        logic        t_push  = pix_valid && pix_ready;
        logic [21:0] t_ent   = {pix_addr, pix_data};
        logic        t_blank = (xx >= 11'd640) || (yy >= 10'd480);
        logic        t_vb    = (yy >= 10'd480);
        int          t_xx    = int'(xx);
        logic        commit;
        int          period;
        @(posedge clk);
        commit = vb_q && !vb_qq;
        if (t_rst) begin
            m_sh_x = '0; m_sh_y = '0; m_sh_ctrl = '0;
            m_x0 = '0; m_y0 = '0; m_en = 1'b0; m_tick = 1'b0;
            m_cnt = 0; m_page = 0;
            q.delete();
        end else begin
            m_tick = commit;
            if (commit) begin
                m_x0 = m_sh_x;
                m_y0 = m_sh_y;
                m_en = m_sh_ctrl[0];
                period = int'(m_sh_ctrl[15:8]);
                if (m_sh_ctrl[16]) begin
                    m_cnt = 0;
                    m_page = 0;
                end else if (period != 0) begin
                    if (m_cnt >= period - 1) begin
                        m_cnt = 0;
                        m_page = (m_page + 1) % FRAMES;
                    end else begin
                        m_cnt++;
                    end
                end
                m_sh_ctrl[16] = 1'b0;
            end
            if (t_we) begin
                case (t_addr)
                    2'd0: m_sh_x = t_data;
                    2'd1: m_sh_y = t_data;
                    2'd2: m_sh_ctrl = t_data;
                    default: ;
                endcase
            end
        end
        vb_qq = t_rst ? 1'b0 : vb_q;
        vb_q  = t_rst ? 1'b0 : t_vb;
        #1;
        check("x0", x0, m_x0);
        check("y0", y0, m_y0);
        check("sprite_en", sprite_en, m_en);
        check("frame_tick", frame_tick, m_tick);
        check("anim_page", anim_page, m_page);
        if (frame_tick) n_ticks++;
        if (q.size() == 0 || !t_blank) begin
            check("spurious_we", sprite_ram_we, 0);
        end else if (sprite_ram_we) begin
            check("we_addr", sprite_ram_addr_w, q[0][21:12]);
            check("we_data", sprite_ram_din, q[0][11:0]);
            void'(q.pop_front());
            pop_xx.push_back(t_xx);
        end
        if (t_push && !t_rst) q.push_back(t_ent);
        check("pix_ready", pix_ready, q.size() < DEPTH);
    endtask

    task automatic frame(input bit rnd, input bit poke_x0, input logic [31:0] poke_val);
        int lines[5] = '{10, 200, 479, 480, 500};
        for (int li = 0; li < 5; li++) begin
            for (int x = 620; x <= 660; x++) begin
                xx = 11'(x);
                yy = 10'(lines[li]);
                cfg_we = 1'b0;
                pix_valid = 1'b0;
                if (poke_x0 && lines[li] == 480 && x == 621) begin
                    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = poke_val;
                end else if (rnd) begin
                    if ($urandom_range(15) == 0) begin
                        cfg_we = 1'b1;
                        cfg_addr = 2'($urandom_range(3));
                        cfg_wdata = $urandom;
                        if (cfg_addr == 2'd2) begin
                            cfg_wdata[15:8] = 8'($urandom_range(3));
                            cfg_wdata[16] = ($urandom_range(7) == 0);
                        end
                    end
                    pix_valid = ($urandom_range(2) == 0);
                    pix_addr  = 10'($urandom);
                    pix_data  = 12'($urandom);
                end
                tick();
            end
        end
        cfg_we = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    logic [11:0] t4_data[3] = '{12'hF00, 12'h0F0, 12'h00F};

    initial begin
        int idx;
        bit seen_full;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_x0", x0, 0);
        check("rst_y0", y0, 0);
        check("rst_en", sprite_en, 0);
        check("rst_page", anim_page, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_we", sprite_ram_we, 0);
        check("rst_ready", pix_ready, 1);

        // first commit
        yy = 10'd10; xx = 11'd100;
        cfg_write(2'd0, 32'd100);
        cfg_write(2'd1, 32'd50);
        cfg_write(2'd2, 32'd1);
        check("t1_x0_pre", x0, 0);
        n_ticks = 0;
        frame(1'b0, 1'b0, '0);
        check("t1_x0", x0, 100);
        check("t1_y0", y0, 50);
        check("t1_en", sprite_en, 1);
        check("t1_ticks", n_ticks, 1);

        // write landing in the commit cycle
        frame(1'b0, 1'b1, 32'd200);
        check("t2_x0_hold", x0, 100);
        frame(1'b0, 1'b0, '0);
        check("t2_x0_new", x0, 200);

        // animation paging with period 2
        yy = 10'd10; xx = 11'd100;
        cfg_write(2'd2, 32'h0000_0201);
        check("t3_page_k0", anim_page, 0);
        for (int k = 1; k <= 10; k++) begin
            frame(1'b0, 1'b0, '0);
            check("t3_page", anim_page, (k / 2) % FRAMES);
        end
        yy = 10'd10; xx = 11'd100;
        cfg_write(2'd2, 32'h0001_0201);
        frame(1'b0, 1'b0, '0);
        check("t3_reset_page", anim_page, 0);
        frame(1'b0, 1'b0, '0);
        frame(1'b0, 1'b0, '0);
        check("t3_after_reset", anim_page, 1);

        // three pixel writes, drained once the line enters blanking
        yy = 10'd100;
        pop_xx.delete();
        for (int x = 10; x <= 660; x++) begin
            xx = 11'(x);
            pix_valid = (x < 13);
            pix_addr  = 10'(x - 5);
            pix_data  = (x < 13) ? t4_data[x - 10] : 12'h0;
            tick();
        end
        pix_valid = 1'b0;
        check("t4_nwrites", pop_xx.size(), 3);
        if (pop_xx.size() == 3) begin
            check("t4_pop0_xx", pop_xx[0], 641);
            check("t4_pop1_xx", pop_xx[1], 642);
            check("t4_pop2_xx", pop_xx[2], 643);
        end

        // nine back-to-back writes into an eight-deep FIFO
        idx = 0;
        seen_full = 1'b0;
        for (int x = 0; x <= 700; x++) begin
            bit was_ready;
            xx = 11'(x);
            pix_valid = (idx < 9);
            pix_addr  = 10'(100 + idx);
            pix_data  = 12'(idx * 37 + 1);
            was_ready = pix_ready;
            tick();
            if (idx < 9 && was_ready) idx++;
            if (idx == 8 && !seen_full) begin
                check("t5_full", pix_ready, 0);
                seen_full = 1'b1;
            end
        end
        pix_valid = 1'b0;
        check("t5_pushed", idx, 9);
        check("t5_drained", q.size(), 0);

        // reset while draining four entries
        for (int x = 0; x < 4; x++) begin
            xx = 11'(x);
            pix_valid = 1'b1;
            pix_addr = 10'(300 + x);
            pix_data = 12'($urandom);
            tick();
        end
        pix_valid = 1'b0;
        xx = 11'd639; tick();
        xx = 11'd640; tick();
        pop_xx.delete();
        xx = 11'd641; rst = 1'b1; tick();
        rst = 1'b0;
        check("t6_we", sprite_ram_we, 0);
        check("t6_ready", pix_ready, 1);
        for (int x = 642; x <= 680; x++) begin
            xx = 11'(x);
            tick();
        end
        check("t6_nowrites", pop_xx.size(), 0);

        // randomized traffic
        for (int f = 0; f < 14; f++) frame(1'b1, 1'b0, '0);
        for (int f = 0; f < 3; f++) frame(1'b0, 1'b0, '0);
        check("final_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
